matrix_line_loader: RTL

- Input-side counterpart of the encoder's line writer.
- Accepts a 5x5x64 matrix as a stream of 25-bit lines over a valid/ready handshake and stores the lines in an internal DEPTH x N buffer.
- Flags completion, then serves the stored slices to the encoder datapath through a registered random-read port until released.
- Line ordering matches the encoder's slice counter: the first received line is slice DEPTH-1 (63), the last is slice 0.

---
 rtl/matrix_line_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/matrix_line_loader.sv
// -----------------------------------------------------------------------------
// matrix_line_loader
//
// Input-side counterpart of the encoder's line writer. A 5x5x64 matrix arrives
// as DEPTH lines of N bits over a valid/ready handshake and is stored in an
// internal DEPTH x N buffer. Once all lines are in, full_o is raised and the
// encoder datapath reads slices through a registered random-read port until it
// pulses release_i.
//
// The first received line is slice DEPTH-1 and the last is slice 0, so the
// write pointer counts down. This matches the encoder's slice counter.
//
// Ports:
//   clk_i       clock; every state change happens on the rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     one-cycle pulse that arms a new load (honoured only in IDLE)
//   in_valid_i  in_line_i / in_last_i are valid this cycle
//   in_line_i   incoming line; bit N-1 is the first character of the text line
//   in_last_i   source marks the final line of the matrix
//   in_ready_o  loader can accept a line this cycle
//   full_o      all DEPTH lines are stored and the buffer is readable
//   err_o       sticky framing error (in_last_i seen on the wrong line)
//   rd_addr_i   slice index to read
//   rd_en_i     read request (serviced only while full)
//   rd_data_o   registered read data, one cycle after rd_en_i
//   rd_valid_o  rd_data_o is valid this cycle
//   release_i   one-cycle pulse: consumer is done, return to IDLE
//   count_o     lines accepted in the current load (0..DEPTH)
// -----------------------------------------------------------------------------
module matrix_line_loader #(
   parameter int N     = 25,
   parameter int DEPTH = 64,
   parameter int AW    = 6    // 2**AW must equal DEPTH
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          in_valid_i,
   input  logic [N-1:0]  in_line_i,
   input  logic          in_last_i,
   output logic          in_ready_o,
   output logic          full_o,
   output logic          err_o,
   input  logic [AW-1:0] rd_addr_i,
   input  logic          rd_en_i,
   output logic [N-1:0]  rd_data_o,
   output logic          rd_valid_o,
   input  logic          release_i,
   output logic [AW:0]   count_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FULL = 2'd2
   } state_t;

   localparam logic [AW-1:0] WPTR_TOP  = AW'(DEPTH - 1);
   localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(DEPTH);

   state_t          state_q;
   logic [AW-1:0]   wptr_q;
   logic [AW:0]     count_q;
   logic            in_ready_q;
   logic            full_q;
   logic            err_q;
   logic            rd_valid_q;
   logic [N-1:0]    rd_data_q;

   // Line buffer; contents survive reset and are never cleared.
   logic [N-1:0]    mem [DEPTH];

   logic            accept;
   logic            last_slot;
   logic [AW-1:0]   wptr_d;
   logic [AW:0]     count_d;

   // in_ready_q is high exactly while in LOAD, so it doubles as the
   // handshake qualifier.
   assign accept    = in_valid_i & in_ready_q;
   assign last_slot = (wptr_q == '0);

   // Pointer and counter values applied on an accepted line. Both hold at
   // their end stops so the pointer never wraps and the count saturates.
   assign wptr_d  = last_slot ? wptr_q : wptr_q - 1'b1;
   assign count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;

   // Buffer write port, kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         mem[wptr_q] <= in_line_i;
      end
   end

   // Control FSM with registered outputs and the registered read port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         wptr_q     <= WPTR_TOP;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         full_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         // A read strobe lasts one cycle unless another read is issued.
         rd_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q    <= S_LOAD;
                  in_ready_q <= 1'b1;
                  err_q      <= 1'b0;
                  count_q    <= '0;
                  wptr_q     <= WPTR_TOP;
               end
            end

            S_LOAD: begin
               if (accept) begin
                  wptr_q  <= wptr_d;
                  count_q <= count_d;
                  // in_last must coincide exactly with the final slot.
                  if (in_last_i != last_slot) begin
                     err_q <= 1'b1;
                  end
                  if (last_slot) begin
                     state_q    <= S_FULL;
                     in_ready_q <= 1'b0;
                     full_q     <= 1'b1;
                  end
               end
            end

            S_FULL: begin
               // A read issued together with release still completes.
               if (rd_en_i) begin
                  rd_valid_q <= 1'b1;
                  rd_data_q  <= mem[rd_addr_i];
               end
               if (release_i) begin
                  state_q <= S_IDLE;
                  full_q  <= 1'b0;
               end
            end

            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b0;
               full_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o = in_ready_q;
   assign full_o     = full_q;
   assign err_o      = err_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign count_o    = count_q;

endmodule
